pc_predict: RTL
===============

// Module: pc_predict
// PURPOSE
//  Fetch-stage program counter with a direct-mapped branch target buffer (BTB) and
//  2-bit saturating direction counters. Replaces the fixed 32-bit PC unit.
//  Drives the instruction fetch address each cycle and predicts the next fetch address.
//  Accepts redirects (mispredict, jr, j) and BTB training updates from the
//  branch-resolution stage.
// PARAMETERS
//  PC_INIT      32'h0000_0000  PC value loaded on reset.
//  BTB_ENTRIES  8              BTB depth; power of two, 2..64.
//  CTR_INIT     2'b01          Counter value on reset (weakly not-taken).
// PORTS
//  CLK            in   1   System clock, rising edge.
//  nRST           in   1   Asynchronous active-low reset.
//  pcenable       in   1   1 = advance the PC this cycle; 0 = stall (hold the PC).
//  redirect       in   1   Resolved-path correction (mispredict/jr/j).
//  redirect_pc    in   32  Correct next PC when redirect=1.
//  upd_valid      in   1   Train the BTB with a resolved branch.
//  upd_pc         in   32  PC of the resolved branch.
//  upd_taken      in   1   Actual branch direction.
//  upd_target     in   32  Actual taken target.
//  imemaddr       out  32  Current fetch PC (registered).
//  npc            out  32  imemaddr + 4, forwarded for link/branch arithmetic.
//  pred_taken     out  1   Prediction applied to this fetch.
//  pred_target    out  32  BTB target (valid only when pred_taken=1).
// BEHAVIOUR
//  - Reset (nRST=0, asynchronous):
//    - imemaddr=PC_INIT.
//    - All BTB valid bits=0 and all counters=CTR_INIT.
//    - Consequently pred_taken=0 and pred_target=0 on reset.
//  - Index and tag: IDX_W=$clog2(BTB_ENTRIES); idx=pc[IDX_W+1:2]; tag=pc[31:IDX_W+2].
//  - Lookup (combinational on imemaddr):
//    - hit = valid[idx] & (tag matches).
//    - pred_taken = hit & ctr[idx][1].
//    - pred_target = hit ? target[idx] : 0.
//  - Next-PC priority (applied at the clock edge):
//    1. redirect=1 -> imemaddr <= redirect_pc. Applies even when pcenable=0.
//    2. else if pcenable=1 -> imemaddr <= pred_taken ? pred_target : npc.
//    3. else -> hold.
//  - Latency: one cycle from the redirect edge to the new imemaddr. There is no bubble
//    beyond that cycle.
//  - Alignment: bits [1:0] of redirect_pc and upd_target are ignored and stored/loaded
//    as 2'b00. imemaddr[1:0] is always 00.
//  - Arithmetic: npc = imemaddr + 32'd4, mod 2^32 (32'hFFFF_FFFC wraps to 0).
//  - BTB update on upd_valid (clock edge), using upd_pc's own idx and tag:
//    - Hit, taken: ctr += 1, saturating at 2'b11; target <= upd_target.
//    - Hit, not-taken: ctr -= 1, saturating at 2'b00; target is unchanged.
//    - Miss, taken: allocate the entry (overwriting it): valid=1, tag, target, ctr=2'b10.
//    - Miss, not-taken: no change.
//  - Update-versus-lookup at the same index in the same cycle:
//    - Lookup sees pre-update contents; there is no bypass.
//    - The update still commits.
//  - redirect and upd_valid may be asserted together; both take effect.
//  - upd_valid is honoured regardless of pcenable.
// STRUCTURE
//  - cpu_types_pkg gains the following; PC_INIT remains a module parameter:
//    - word_t (existing).
//    - typedef logic [1:0] bpctr_t.
//    - localparam bpctr_t WNT=2'b01, WT=2'b10.
//  - Sub-module btb: storage, lookup port, update port and counter saturation.
//    pc_predict holds the PC register and the next-PC mux.
//  - Interface pc_predict_if:
//    - modport pcp for this block.
//    - modport tb for the bench.
// TESTING
//  1. Reset: hold nRST low for 2 cycles, release with pcenable=1
//     -> imemaddr 0,4,8,C; pred_taken=0 throughout.
//  2. Train: upd_valid, upd_pc=0x10, taken, target=0x40; then fetch reaches 0x10
//     -> pred_taken=1; next imemaddr=0x40.
//  3. Saturation: 3 not-taken updates at 0x10 (10->01->00->00)
//     -> no prediction at 0x10; 3 taken updates take it to 11.
//  4. Priority: redirect=1, redirect_pc=0x200, pcenable=0, BTB hit pending
//     -> imemaddr=0x200 next cycle.
//  5. Alias: with 8 entries, train 0x10 then 0x30 (same idx, different tag)
//     -> 0x10 misses afterwards.
//  6. Wrap/async: PC=0xFFFFFFFC advancing -> 0x0. Drop nRST mid-cycle
//     -> imemaddr=PC_INIT before the next edge.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch stage: word type, branch-direction counter
// type and its saturating step helper.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [1:0]  bpctr_t;

  localparam bpctr_t SNT = 2'b00;
  localparam bpctr_t WNT = 2'b01;
  localparam bpctr_t WT  = 2'b10;
  localparam bpctr_t ST  = 2'b11;

  // Move a 2-bit direction counter one step toward the observed outcome.
  function automatic bpctr_t ctr_step(input bpctr_t c, input logic taken);
    if (taken) begin
      return (c == ST) ? ST : c + 2'b01;
    end
    return (c == SNT) ? SNT : c - 2'b01;
  endfunction

endpackage

// File: rtl/pc_predict_if.sv
// Bundle of the fetch-PC predictor signals, with one view for the block and
// one for a driver/monitor.
interface pc_predict_if (input logic CLK);

  logic        nRST;
  logic        pcenable;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] imemaddr;
  logic [31:0] npc;
  logic        pred_taken;
  logic [31:0] pred_target;

  modport pcp (
    input  CLK, nRST, pcenable, redirect, redirect_pc,
           upd_valid, upd_pc, upd_taken, upd_target,
    output imemaddr, npc, pred_taken, pred_target
  );

  modport tb (
    input  CLK, imemaddr, npc, pred_taken, pred_target,
    output nRST, pcenable, redirect, redirect_pc,
           upd_valid, upd_pc, upd_taken, upd_target
  );

endinterface

// File: rtl/btb.sv
// Direct-mapped branch target buffer with 2-bit direction counters:
// one combinational lookup port and one clocked training port.
module btb
  import cpu_types_pkg::*;
#(
  parameter int     ENTRIES  = 8,
  parameter bpctr_t CTR_INIT = WNT
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:2] lookup_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:2] upd_pc,
  input  logic        upd_taken,
  input  logic [31:2] upd_target
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] valid;
  bpctr_t             ctr     [ENTRIES];
  logic [TAG_W-1:0]   tags    [ENTRIES];
  logic [29:0]        targets [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[31:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[31:IDX_W+2];

  assign lk_hit = valid[lk_idx] && (tags[lk_idx] == lk_tag);
  assign up_hit = valid[up_idx] && (tags[up_idx] == up_tag);

  assign pred_taken  = lk_hit && ctr[lk_idx][1];
  assign pred_target = lk_hit ? {targets[lk_idx], 2'b00} : 32'h0;

  // Valid bits and counters are reset; a taken miss allocates as weakly taken.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr[i] <= CTR_INIT;
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        ctr[up_idx] <= ctr_step(ctr[up_idx], upd_taken);
      end else if (upd_taken) begin
        valid[up_idx] <= 1'b1;
        ctr[up_idx]   <= WT;
      end
    end
  end

  // Tag and target only matter behind a valid bit, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (upd_valid && upd_taken) begin
      tags[up_idx]    <= up_tag;
      targets[up_idx] <= upd_target;
    end
  end

endmodule

// File: rtl/pc_predict.sv
// Fetch-stage program counter: PC register plus next-PC selection between
// redirect, BTB prediction and sequential fetch.
module pc_predict
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT     = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 8,
  parameter bpctr_t      CTR_INIT    = WNT
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        pcenable,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic [31:0] imemaddr,
  output logic [31:0] npc,
  output logic        pred_taken,
  output logic [31:0] pred_target
);

  logic [31:2] pc_q, pc_d;
  logic        unused_low_bits;

  // Word alignment is structural: only bits [31:2] are ever stored.
  assign unused_low_bits = ^{redirect_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  assign imemaddr = {pc_q, 2'b00};
  assign npc      = imemaddr + 32'd4;

  btb #(
    .ENTRIES  (BTB_ENTRIES),
    .CTR_INIT (CTR_INIT)
  ) u_btb (
    .CLK         (CLK),
    .nRST        (nRST),
    .lookup_pc   (pc_q),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc[31:2]),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target[31:2])
  );

  // A redirect wins over everything, including a stall.
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_pc[31:2];
    end else if (pcenable) begin
      pc_d = pred_taken ? pred_target[31:2] : npc[31:2];
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_q <= PC_INIT[31:2];
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule
